// File: rtl/mat_loader_pkg.sv
// rtl/mat_loader_pkg.sv - shared loader state encoding and element packing helper
package mat_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    // Bit offset of element k (row-major) inside an n-element, w-bit flattened
    // matrix; element 0 sits in the most significant slot.
    function automatic int elem_offset(input int k, input int n, input int w);
        return (n - 1 - k) * w;
    endfunction

endpackage

// File: rtl/mat_loader.sv
// rtl/mat_loader.sv - streams row-major elements into a flattened R x C matrix
module mat_loader
    import mat_loader_pkg::*;
#(
    parameter int R = 3,
    parameter int C = 2,
    parameter int W = 8,
    localparam int RW = (R > 1) ? $clog2(R) : 1,
    localparam int CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [W-1:0]       in_data,
    output logic               in_ready,
    output logic [R*C*W-1:0]   mat,
    output logic               loaded,
    output logic [RW-1:0]      row,
    output logic [CW-1:0]      col
);

    localparam int              N        = R * C;
    localparam logic [RW-1:0]   ROW_LAST = RW'(R - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(C - 1);

    ld_state_e  state;
    ld_state_e  next_state;
    logic       accept;
    logic       last_elem;
    int         k_idx;

    assign in_ready  = (state == LOAD);
    assign loaded    = (state == DONE);
    // A start in the same cycle as a beat restarts the load, so that beat is dropped.
    assign accept    = in_valid && in_ready && !start;
    assign last_elem = (row == ROW_LAST) && (col == COL_LAST);
    assign k_idx     = int'(row) * C + int'(col);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: start always (re)enters LOAD; the final accepted beat finishes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                if (start)                      next_state = LOAD;
                else if (accept && last_elem)   next_state = DONE;
            end
            DONE: begin
                if (start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Row/column cursor and matrix storage; mat only changes on accepted beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
            mat <= '0;
        end else if (start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            for (int e = 0; e < N; e++) begin
                if (k_idx == e) begin
                    mat[elem_offset(e, N, W) +: W] <= in_data;
                end
            end
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
